// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready pipeline applying a bitwise gate function selected by opcode
module logic_unit_pipe #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_err,
    output logic [CNT_W-1:0] out_cnt
);
    logic             s1_valid, s2_valid, s1_free, s2_free, f_err;
    logic [WIDTH-1:0] s1_a, s1_b, f_res;
    logic [2:0]       s1_op;
    assign s2_free   = !s2_valid || out_ready;
    assign s1_free   = !s1_valid || s2_free;
    assign in_ready  = s1_free;
    assign out_valid = s2_valid;
    always_comb begin
        f_res = s1_op == 3'd0 ? ~(s1_a & s1_b) :
                s1_op == 3'd1 ? ~s1_a :
                s1_op == 3'd2 ? s1_a & s1_b :
                s1_op == 3'd3 ? s1_a | s1_b :
                s1_op == 3'd4 ? s1_a ^ s1_b : '0;
        f_err = s1_op > 3'd4;
    end
    always_ff @(posedge clk)
        if (in_valid && s1_free) begin
            s1_a  <= in_a;
            s1_b  <= in_b;
            s1_op <= in_op;
        end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            out_res  <= '0;
            out_err  <= 1'b0;
            out_cnt  <= '0;
        end else begin
            if (s1_free) s1_valid <= in_valid;
            if (s2_free) s2_valid <= s1_valid;
            if (s1_valid && s2_free) begin
                out_res <= f_res;
                out_err <= f_err;
            end
            if (s2_valid && out_ready) out_cnt <= out_cnt + 1'b1;
        end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed and randomized-stall checks of logic_unit_pipe
module tb_logic_unit_pipe;
    logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic        in_ready, out_valid, out_err;
    logic [15:0] in_a = 0, in_b = 0, out_res;
    logic [2:0]  in_op = 0;
    logic [7:0]  out_cnt;
    int pass = 0, total = 0;

    logic_unit_pipe #(.WIDTH(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_res(out_res), .out_err(out_err), .out_cnt(out_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] model(input logic [15:0] a, b, input logic [2:0] op);
        case (op)
            3'd0: return {1'b0, ~(a & b)};
            3'd1: return {1'b0, ~a};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            default: return {1'b1, 16'h0000};
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        in_valid = 0;
        out_ready = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic beat(input logic [15:0] a, b, input logic [2:0] op);
        in_valid = 1;
        in_a = a;
        in_b = b;
        in_op = op;
    endtask

    task automatic test_reset;
        do_reset();
        out_ready = 1;
        beat(16'h00FF, 16'h0F0F, 3'd2);
        tick();
        in_valid = 0;
        tick();
        tick();
        out_ready = 0;
        beat(16'h1111, 16'h2222, 3'd3);
        tick();
        beat(16'h3333, 16'h4444, 3'd4);
        tick();
        in_valid = 0;
        total++; if (out_valid !== 1'b1 || out_cnt !== 8'd1) $display("FAIL reset_pre valid=%b cnt=%0d exp valid=1 cnt=1", out_valid, out_cnt); else pass++;
        #2 rst = 1;
        #1;
        total++; if (out_valid !== 1'b0 || out_res !== 16'h0 || out_err !== 1'b0 || out_cnt !== 8'd0)
            $display("FAIL reset_async valid=%b res=%h err=%b cnt=%0d exp 0/0000/0/0", out_valid, out_res, out_err, out_cnt); else pass++;
        #1 rst = 0;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else pass++;
        out_ready = 1;
        tick();
        tick();
        total++; if (out_valid !== 1'b0 || out_cnt !== 8'd0) $display("FAIL reset_no_replay valid=%b cnt=%0d exp 0/0", out_valid, out_cnt); else pass++;
    endtask

    task automatic test_stream;
        logic [15:0] exp [5] = '{16'h0FFF, 16'h0F0F, 16'hF000, 16'hFFF0, 16'h0FF0};
        do_reset();
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) beat(16'hF0F0, 16'hFF00, 3'(i)); else in_valid = 0;
            tick();
            if (i == 0) begin
                total++; if (out_valid !== 1'b0) $display("FAIL stream_latency valid=%b exp 0", out_valid); else pass++;
            end else begin
                total++; if (out_valid !== 1'b1 || out_res !== exp[i-1] || out_err !== 1'b0)
                    $display("FAIL stream_res%0d valid=%b res=%h err=%b exp 1/%h/0", i-1, out_valid, out_res, out_err, exp[i-1]); else pass++;
            end
        end
        tick();
        total++; if (out_valid !== 1'b0 || out_cnt !== 8'd5) $display("FAIL stream_cnt valid=%b cnt=%0d exp 0/5", out_valid, out_cnt); else pass++;
    endtask

    task automatic test_illegal;
        do_reset();
        out_ready = 1;
        beat(16'h1234, 16'hFFFF, 3'd6);
        tick();
        beat(16'h1234, 16'h00FF, 3'd2);
        tick();
        in_valid = 0;
        total++; if (out_valid !== 1'b1 || out_res !== 16'h0 || out_err !== 1'b1) $display("FAIL illegal_op valid=%b res=%h err=%b exp 1/0000/1", out_valid, out_res, out_err); else pass++;
        tick();
        total++; if (out_valid !== 1'b1 || out_res !== 16'h0034 || out_err !== 1'b0) $display("FAIL illegal_next valid=%b res=%h err=%b exp 1/0034/0", out_valid, out_res, out_err); else pass++;
        beat(16'h0000, 16'h0000, 3'd7);
        tick();
        in_valid = 0;
        tick();
        total++; if (out_res !== 16'h0 || out_err !== 1'b1) $display("FAIL illegal_op7 res=%h err=%b exp 0000/1", out_res, out_err); else pass++;
    endtask

    task automatic test_backpressure;
        do_reset();
        beat(16'h0001, 16'h0010, 3'd3);
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL bp_ready0 got %b exp 1", in_ready); else pass++;
        tick();
        beat(16'h0100, 16'h1000, 3'd4);
        tick();
        beat(16'h00FF, 16'h1234, 3'd1);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_res !== 16'h0011)
                $display("FAIL bp_hold%0d ready=%b valid=%b res=%h exp 0/1/0011", i, in_ready, out_valid, out_res); else pass++;
            tick();
        end
        out_ready = 1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_comb got %b exp 1", in_ready); else pass++;
        tick();
        in_valid = 0;
        total++; if (out_valid !== 1'b1 || out_res !== 16'h1100) $display("FAIL bp_res1 valid=%b res=%h exp 1/1100", out_valid, out_res); else pass++;
        tick();
        total++; if (out_valid !== 1'b1 || out_res !== 16'hFF00) $display("FAIL bp_res2 valid=%b res=%h exp 1/ff00", out_valid, out_res); else pass++;
        tick();
        total++; if (out_valid !== 1'b0 || out_cnt !== 8'd3) $display("FAIL bp_cnt valid=%b cnt=%0d exp 0/3", out_valid, out_cnt); else pass++;
    endtask

    task automatic test_wrap;
        do_reset();
        out_ready = 1;
        for (int i = 0; i < 257; i++) begin
            beat(16'(i), 16'h5555, 3'd4);
            tick();
        end
        in_valid = 0;
        tick();
        tick();
        tick();
        total++; if (out_valid !== 1'b0 || out_cnt !== 8'd1) $display("FAIL wrap_cnt valid=%b cnt=%0d exp 0/1", out_valid, out_cnt); else pass++;
    endtask

    task automatic test_random;
        logic [16:0] q [$];
        logic [16:0] e;
        int occ = 0, n = 0;
        bit hold = 0, in_fire, out_fire;
        do_reset();
        for (int i = 0; i < 1004; i++) begin
            if (i >= 1000) begin
                in_valid = 0;
                out_ready = 1;
            end else begin
                if (!hold) begin
                    in_valid = $urandom_range(0, 3) != 0;
                    in_a = 16'($urandom);
                    in_b = 16'($urandom);
                    in_op = 3'($urandom_range(0, 7));
                end
                out_ready = $urandom_range(0, 2) != 0;
            end
            #3;
            total++; if (in_ready !== (occ < 2 || out_ready)) $display("FAIL rand_ready cyc=%0d got %b exp %b", i, in_ready, occ < 2 || out_ready); else pass++;
            in_fire = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (out_fire) begin
                e = q.size() > 0 ? q.pop_front() : 17'h1FFFF;
                n++;
                total++; if ({out_err, out_res} !== e) $display("FAIL rand_res cyc=%0d got %h exp %h", i, {out_err, out_res}, e); else pass++;
            end
            if (in_fire) q.push_back(model(in_a, in_b, in_op));
            occ += int'(in_fire) - int'(out_fire);
            hold = in_valid && !in_ready;
            tick();
        end
        total++; if (q.size() != 0 || out_cnt !== 8'(n)) $display("FAIL rand_cnt left=%0d cnt=%0d exp 0/%0d", q.size(), out_cnt, n % 256); else pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_illegal();
        test_backpressure();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
